// File: rtl/multichannel_lockin_decimator.sv
// Multichannel lock-in demodulator with accumulate-and-dump decimation.
// One shared multiplier is time-multiplexed over all channel/reference pairs;
// I/Q products are summed over 2^DEC_LOG2 input ticks and then dumped.
module multichannel_lockin_decimator #(
    parameter int NUM_CH   = 4,
    parameter int DATA_W   = 24,
    parameter int DEC_LOG2 = 7,
    parameter int OUT_W    = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick_i,
    input  logic [DATA_W-1:0]          ref_sin_i,
    input  logic [DATA_W-1:0]          ref_cos_i,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data_i,
    output logic [NUM_CH*OUT_W-1:0]    x_o,
    output logic [NUM_CH*OUT_W-1:0]    y_o,
    output logic                       done_o,
    output logic                       busy_o,
    output logic                       overrun_o,
    output logic [31:0]                count_o
);

    localparam int ACC_W  = 2*DATA_W + DEC_LOG2;
    localparam int PROD_W = 2*DATA_W;
    localparam int NSTEP  = 2*NUM_CH;
    localparam int IDX_W  = $clog2(NSTEP);
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int SC_W   = (DEC_LOG2 > 0) ? DEC_LOG2 : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MAC   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DUMP  = 2'd3;

    logic [1:0]               state;
    logic [IDX_W-1:0]         step;
    logic [CH_W-1:0]          step_ch;
    logic signed [DATA_W-1:0] ch_snap [NUM_CH];
    logic signed [DATA_W-1:0] sin_snap;
    logic signed [DATA_W-1:0] cos_snap;
    logic signed [DATA_W-1:0] mul_a;
    logic signed [DATA_W-1:0] mul_b;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic                     prod_vld;
    logic [CH_W-1:0]          prod_ch;
    logic                     prod_is_cos;
    logic signed [ACC_W-1:0]  accx [NUM_CH];
    logic signed [ACC_W-1:0]  accy [NUM_CH];
    logic [SC_W-1:0]          sample_cnt;
    logic                     frame_full;

    assign busy_o     = (state != IDLE);
    assign prod_ext   = ACC_W'(prod);
    // With DEC_LOG2 == 0 every sample is a full frame.
    assign frame_full = (DEC_LOG2 == 0) ? 1'b1 : (sample_cnt == '1);

    // Multiplier operand select: even steps use sin, odd steps use cos.
    always_comb begin
        step_ch = CH_W'(step >> 1);
        mul_a   = ch_snap[step_ch];
        mul_b   = step[0] ? cos_snap : sin_snap;
    end

    // FSM, product pipeline register, accumulators and output dump.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            step        <= '0;
            sin_snap    <= '0;
            cos_snap    <= '0;
            prod        <= '0;
            prod_vld    <= 1'b0;
            prod_ch     <= '0;
            prod_is_cos <= 1'b0;
            sample_cnt  <= '0;
            x_o         <= '0;
            y_o         <= '0;
            done_o      <= 1'b0;
            overrun_o   <= 1'b0;
            count_o     <= '0;
            for (int unsigned k = 0; k < NUM_CH; k++) begin
                ch_snap[k] <= '0;
                accx[k]    <= '0;
                accy[k]    <= '0;
            end
        end else begin
            done_o <= 1'b0;

            if (tick_i && (state != IDLE))
                overrun_o <= 1'b1;

            // Product issued last cycle lands in its own accumulator now.
            if (prod_vld) begin
                if (prod_is_cos)
                    accy[prod_ch] <= accy[prod_ch] + prod_ext;
                else
                    accx[prod_ch] <= accx[prod_ch] + prod_ext;
            end

            prod_vld <= (state == MAC);
            if (state == MAC) begin
                prod        <= mul_a * mul_b;
                prod_ch     <= step_ch;
                prod_is_cos <= step[0];
            end

            case (state)
                IDLE: begin
                    if (tick_i) begin
                        for (int unsigned k = 0; k < NUM_CH; k++)
                            ch_snap[k] <= ch_data_i[k*DATA_W +: DATA_W];
                        sin_snap <= ref_sin_i;
                        cos_snap <= ref_cos_i;
                        step     <= '0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (step == IDX_W'(NSTEP-1))
                        state <= DRAIN;
                    else
                        step <= step + 1'b1;
                end
                DRAIN: begin
                    sample_cnt <= sample_cnt + 1'b1;
                    state      <= frame_full ? DUMP : IDLE;
                end
                default: begin
                    for (int unsigned k = 0; k < NUM_CH; k++) begin
                        x_o[k*OUT_W +: OUT_W] <= accx[k][ACC_W-1 -: OUT_W];
                        y_o[k*OUT_W +: OUT_W] <= accy[k][ACC_W-1 -: OUT_W];
                        accx[k] <= '0;
                        accy[k] <= '0;
                    end
                    done_o  <= 1'b1;
                    count_o <= count_o + 32'd1;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multichannel_lockin_decimator.sv
// Directed bench for multichannel_lockin_decimator (2 channels, 4-tick frames).
// A behavioural model predicts each dumped frame and its done cycle; a
// monitor pops the scoreboard whenever the frame is due.
module tb_multichannel_lockin_decimator;

    localparam int NUM_CH = 2, DATA_W = 24, DEC_LOG2 = 2, OUT_W = 32;
    localparam int SHIFT = 2*DATA_W + DEC_LOG2 - OUT_W;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     tick_i = 1'b0;
    logic [DATA_W-1:0]        ref_sin_i = '0;
    logic [DATA_W-1:0]        ref_cos_i = '0;
    logic [NUM_CH*DATA_W-1:0] ch_data_i = '0;
    logic [NUM_CH*OUT_W-1:0]  x_o;
    logic [NUM_CH*OUT_W-1:0]  y_o;
    logic                     done_o;
    logic                     busy_o;
    logic                     overrun_o;
    logic [31:0]              count_o;

    multichannel_lockin_decimator #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEC_LOG2(DEC_LOG2), .OUT_W(OUT_W)
    ) dut (
        .clk(clk), .reset(reset), .tick_i(tick_i),
        .ref_sin_i(ref_sin_i), .ref_cos_i(ref_cos_i), .ch_data_i(ch_data_i),
        .x_o(x_o), .y_o(y_o), .done_o(done_o), .busy_o(busy_o),
        .overrun_o(overrun_o), .count_o(count_o)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] x0, x1, y0, y1, cnt;
        longint      done_cyc;
    } frame_t;

    frame_t sb[$];
    frame_t fr;
    int     n_pass = 0, n_checks = 0;
    bit     started = 0;

    // Model state
    longint m_ax[2], m_ay[2];
    int     m_cnt = 0;
    int     m_frames = 0;
    longint next_free = 0;
    logic   m_overrun = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                    tag, $signed(obs), obs, $signed(exp), exp);
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin m_ax[k] = 0; m_ay[k] = 0; end
        m_cnt = 0; m_frames = 0; next_free = 0; m_overrun = 1'b0;
        sb.delete();
    endtask

    // Reset for two cycles, optionally with a tick in the first reset cycle.
    task automatic do_reset(input bit with_tick);
        @(posedge clk); #1;
        reset = 1'b1; tick_i = with_tick;
        @(posedge clk); #1;
        tick_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        check("rst_x_lo",  x_o[31:0],  32'd0);
        check("rst_x_hi",  x_o[63:32], 32'd0);
        check("rst_y_lo",  y_o[31:0],  32'd0);
        check("rst_y_hi",  y_o[63:32], 32'd0);
        check("rst_count", count_o,    32'd0);
        check("rst_busy",  {31'd0, busy_o},    32'd0);
        check("rst_ovr",   {31'd0, overrun_o}, 32'd0);
    endtask

    // Drive one tick; next tick is driven `gap` cycles later (gap >= 2).
    task automatic send_tick(input logic signed [23:0] c0, input logic signed [23:0] c1,
                             input logic signed [23:0] s, input logic signed [23:0] co,
                             input int gap);
        longint t;
        frame_t f;
        @(posedge clk); #1;
        ch_data_i = {c1, c0}; ref_sin_i = s; ref_cos_i = co; tick_i = 1'b1;
        t = cyc + 1;
        if (t >= next_free) begin
            m_ax[0] += longint'(c0) * longint'(s);
            m_ay[0] += longint'(c0) * longint'(co);
            m_ax[1] += longint'(c1) * longint'(s);
            m_ay[1] += longint'(c1) * longint'(co);
            m_cnt = (m_cnt + 1) % (1 << DEC_LOG2);
            if (m_cnt == 0) begin
                m_frames++;
                f.x0 = 32'(m_ax[0] >>> SHIFT);
                f.x1 = 32'(m_ax[1] >>> SHIFT);
                f.y0 = 32'(m_ay[0] >>> SHIFT);
                f.y1 = 32'(m_ay[1] >>> SHIFT);
                f.cnt = 32'(m_frames);
                f.done_cyc = t + 2*NUM_CH + 2;
                sb.push_back(f);
                for (int k = 0; k < 2; k++) begin m_ax[k] = 0; m_ay[k] = 0; end
                next_free = t + 2*NUM_CH + 3;
            end else begin
                next_free = t + 2*NUM_CH + 2;
            end
        end else begin
            m_overrun = 1'b1;
        end
        @(posedge clk); #1;
        tick_i = 1'b0;
        ch_data_i = {$urandom, $urandom};
        ref_sin_i = DATA_W'($urandom);
        ref_cos_i = DATA_W'($urandom);
        @(negedge clk);
        check("busy_after_tick", {31'd0, busy_o}, 32'd1);
        check("overrun", {31'd0, overrun_o}, {31'd0, m_overrun});
        repeat (gap - 2) @(posedge clk);
    endtask

    // Scoreboard monitor: done_o must pulse exactly on the predicted cycle.
    always @(negedge clk) begin
        if (started && !reset) begin
            if (sb.size() > 0 && cyc == sb[0].done_cyc) begin
                check("done_pulse", {31'd0, done_o}, 32'd1);
                fr = sb.pop_front();
                check("x0", x_o[31:0],  fr.x0);
                check("x1", x_o[63:32], fr.x1);
                check("y0", y_o[31:0],  fr.y0);
                check("y1", y_o[63:32], fr.y1);
                check("count", count_o, fr.cnt);
            end else begin
                check("done_idle", {31'd0, done_o}, 32'd0);
            end
        end
    end

    initial begin
        int budget;
        model_clear();
        do_reset(1'b1);
        started = 1;

        // In-phase, channel 0
        repeat (4) send_tick(24'sd1000, 24'sd0, 24'sd4194304, 24'sd0, 10);
        // Quadrature, negative, channel 1
        repeat (4) send_tick(24'sd0, -24'sd1000, 24'sd0, 24'sd4194304, 10);
        // Truncation toward -inf
        repeat (4) send_tick(24'sd1, 24'sd0, 24'sd1, 24'sd0, 10);
        repeat (4) send_tick(-24'sd1, 24'sd0, 24'sd1, 24'sd0, 10);
        // Full scale, all negative
        repeat (4) send_tick(-24'sd8388608, -24'sd8388608, -24'sd8388608, -24'sd8388608, 10);
        // Overrun: second tick 3 cycles after the first is dropped
        send_tick(24'sd1000, 24'sd7, 24'sd4194304, 24'sd100, 3);
        send_tick(24'sd1000, 24'sd7, 24'sd4194304, 24'sd100, 10);
        repeat (3) send_tick(24'sd1000, 24'sd7, 24'sd4194304, 24'sd100, 10);
        check("overrun_sticky", {31'd0, overrun_o}, 32'd1);

        // Reset mid-frame, then clean frames
        send_tick(24'sd5000, 24'sd0, 24'sd4194304, 24'sd0, 10);
        send_tick(24'sd5000, 24'sd0, 24'sd4194304, 24'sd0, 3);
        do_reset(1'b0);
        repeat (4) send_tick(24'sd1000, 24'sd0, 24'sd4194304, 24'sd0, 10);
        repeat (12) send_tick(24'sd1000, -24'sd3, 24'sd4194304, -24'sd2097152, 7);
        check("overrun_after_reset", {31'd0, overrun_o}, 32'd0);

        budget = 50;
        while (sb.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        repeat (2) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        check("final_count", count_o, 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
